logic_unit_seq: RTL
===================

// Module: logic_unit_seq
// PURPOSE
//  Parametrised successor to the team's bitwise op primitives. Adds opcode-selected bitwise ops, iterative
//  shifts/rotates (one bit per cycle), zero/parity/error flags and valid/ready handshakes on both sides.
//  Sits between operand fetch and writeback in the datapath as a multi-cycle logic/shift execution unit.
// PARAMETERS
//  WIDTH    8                 operand/result width; power of 2, >= 2
//  SHAMT_W  $clog2(WIDTH)     shift-amount width; derived, do not override
// PORTS
//  clk        in   1         rising-edge clock, single clock domain
//  rst        in   1         asynchronous, active-high reset
//  in_valid   in   1         operands/opcode valid
//  in_ready   out  1         unit can accept; transfer when in_valid && in_ready at rising edge
//  op         in   4         opcode (see BEHAVIOUR)
//  A          in   WIDTH     operand A
//  B          in   WIDTH     operand B; shift amount = B[SHAMT_W-1:0] for shift ops
//  out_valid  out  1         result valid
//  out_ready  in   1         consumer accepts; transfer when out_valid && out_ready at rising edge
//  res        out  WIDTH     registered result
//  zero       out  1         res == 0
//  parity     out  1         XOR-reduce of res (1 = odd number of ones)
//  err        out  1         illegal opcode
// BEHAVIOUR
//  - Opcodes: 0 OR, 1 AND, 2 XOR, 3 NOT A, 4 PASS A, 5 PASS B, 6 NOR, 7 XNOR,
//    8 SLL, 9 SRL, 10 ROL, 11 ROR (A shifted by k = B[SHAMT_W-1:0]); upper B bits ignored.
//    Ops 12-15 are illegal: res = 0, err = 1, latency as a bitwise op.
//  - Reset (async, immediate): state IDLE, res = 0, zero = 0, parity = 0, err = 0, out_valid = 0,
//    shift counter = 0. in_ready is forced 0 while rst is high.
//  - FSM states: IDLE, SHIFT, DONE.
//    IDLE:  in_ready = 1. On accept, a bitwise/illegal op or a shift with k = 0 loads res/flags -> DONE.
//           A shift with k > 0 loads work = A, cnt = k -> SHIFT.
//    SHIFT: in_ready = 0, out_valid = 0. Each edge shifts work by one bit and decrements cnt.
//           SLL/SRL fill with 0. ROL/ROR wrap the MSB or LSB around.
//           On the edge where cnt == 1: res = shifted value, flags computed -> DONE.
//    DONE:  out_valid = 1. res/zero/parity/err held stable until handshake.
//           in_ready = out_ready. If out_ready && in_valid, the new op is accepted on the same edge and
//           processed as from IDLE (back-to-back, no bubble). If out_ready && !in_valid -> IDLE.
//  - Latency: out_valid rises 1 cycle after the accept edge for bitwise/illegal ops and for k = 0.
//    It rises k + 1 cycles after the accept edge for shifts with k > 0.
//  - Throughput: 1 result/cycle for bitwise ops with out_ready held high.
//  - Flags are registered together with res, never computed combinationally from res.
//  - Inputs A/B/op are sampled only at the accept edge; later changes have no effect.
//  - in_valid while busy (SHIFT, or DONE with !out_ready): not accepted. The source must hold its data.
//  - Reset during SHIFT or DONE: the in-flight op is discarded, no output is produced, and the unit
//    is in IDLE at the first edge after rst falls.
// TESTING (WIDTH = 8)
//  1. op=2, A=0xF0, B=0x3C, out_ready=1 -> next cycle: out_valid=1, res=0xCC, zero=0, parity=0, err=0.
//  2. op=10, A=0x81, B=0x03 -> out_valid rises 4 cycles after accept: res=0x0C, parity=0; in_ready=0 throughout SHIFT.
//  3. op=1, A=0xAA, B=0x55, out_ready=0 for 5 cycles -> res=0x00, zero=1 held stable; in_ready=0; a queued
//     op=0 is accepted only on the edge where out_ready=1, and its result 0xFF appears the following cycle.
//  4. Back-to-back ops 0,1,2,6 (A=0x0F, B=0x33), in_valid=out_ready=1 -> res 0x3F, 0x03, 0x3C, 0xC0 on
//     consecutive cycles, no bubbles.
//  5. op=14 -> res=0x00, err=1, zero=1. Then op=9, A=0x80, B=0x08 (k=0) -> 1-cycle latency, res=0x80, err=0.
//  6. op=8, A=0x01, B=0x07; assert rst 3 cycles after accept -> out_valid=0 immediately; after release,
//     op=4, A=0x5A returns res=0x5A, parity=0.

Source files
------------

// File: rtl/logic_unit_seq.sv
// logic_unit_seq: multi-cycle bitwise/shift execution unit with valid/ready handshakes and registered flags
module logic_unit_seq #(
    parameter int WIDTH = 8,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic             zero,
    output logic             parity,
    output logic             err
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t state_q, state_d;
    logic [WIDTH-1:0] res_q, res_d, work_q, work_d, bit_val, ld_val, step;
    logic [SHAMT_W-1:0] cnt_q, cnt_d, k;
    logic [1:0] kind_q, kind_d;
    logic zero_q, zero_d, parity_q, parity_d, err_q, err_d;
    logic bit_err, ld_err, load, accept, is_shift;
    assign k         = B[SHAMT_W-1:0];
    assign is_shift  = op[3:2] == 2'b10;
    assign in_ready  = !rst && (state_q == IDLE || (state_q == DONE && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_valid = state_q == DONE;
    assign res       = res_q;
    assign zero      = zero_q;
    assign parity    = parity_q;
    assign err       = err_q;
    always_comb begin
        step = kind_q == 2'd0 ? {work_q[WIDTH-2:0], 1'b0} :
               kind_q == 2'd1 ? {1'b0, work_q[WIDTH-1:1]} :
               kind_q == 2'd2 ? {work_q[WIDTH-2:0], work_q[WIDTH-1]} :
                                {work_q[0], work_q[WIDTH-1:1]};
    end
    always_comb begin
        bit_val = '0;
        bit_err = 1'b0;
        case (op)
            4'd0:    bit_val = A | B;
            4'd1:    bit_val = A & B;
            4'd2:    bit_val = A ^ B;
            4'd3:    bit_val = ~A;
            4'd4:    bit_val = A;
            4'd5:    bit_val = B;
            4'd6:    bit_val = ~(A | B);
            4'd7:    bit_val = ~(A ^ B);
            4'd8, 4'd9, 4'd10, 4'd11: bit_val = A;
            default: bit_err = 1'b1;
        endcase
    end
    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        kind_d  = kind_q;
        load    = 1'b0;
        ld_val  = bit_val;
        ld_err  = bit_err;
        if (accept && is_shift && k != '0) begin
            work_d  = A;
            cnt_d   = k;
            kind_d  = op[1:0];
            state_d = SHIFT;
        end else if (accept) begin
            load    = 1'b1;
            state_d = DONE;
        end else if (state_q == SHIFT) begin
            work_d = step;
            cnt_d  = cnt_q - SHAMT_W'(1);
            if (cnt_q == SHAMT_W'(1)) begin
                load    = 1'b1;
                ld_val  = step;
                ld_err  = 1'b0;
                state_d = DONE;
            end
        end else if (state_q == DONE && out_ready) begin
            state_d = IDLE;
        end
        res_d    = load ? ld_val : res_q;
        zero_d   = load ? ~|ld_val : zero_q;
        parity_d = load ? ^ld_val : parity_q;
        err_d    = load ? ld_err : err_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            res_q    <= '0;
            work_q   <= '0;
            cnt_q    <= '0;
            kind_q   <= '0;
            zero_q   <= 1'b0;
            parity_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            res_q    <= res_d;
            work_q   <= work_d;
            cnt_q    <= cnt_d;
            kind_q   <= kind_d;
            zero_q   <= zero_d;
            parity_q <= parity_d;
            err_q    <= err_d;
        end
    end
endmodule
